packet_xor_recover: RTL and testbench
=====================================

# packet_xor_recover

Sequential erasure-recovery engine for the EC accelerator datapath; it is the decode-side counterpart of the parity XOR tree. The host names one erased packet slot (data `0..K_MAX-1` or parity `K_MAX`). The host then streams the K_MAX surviving packets in, one per handshake, in any order. The block XOR-accumulates the survivors row by row (W rows of PACKET_LENGTH bits) and presents the reconstructed packet on a valid/ready output.

## Interface
- `W`, 8, rows (words) per packet; taken from `global_parameters.v`
- `K_MAX`, 4, data packets per stripe; taken from `global_parameters.v`
- `PACKET_LENGTH`, 32, bits per row; taken from `global_parameters.v`
- `IDX_W`, `$clog2(K_MAX+1)`, slot-index width; derived, not overridable

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start_i`  in  1  begin a recovery; sampled only in IDLE
- `erased_idx_i`  in  IDX_W  erased slot; latched on accepted start
- `in_valid_i` / `in_ready_o`  in/out  1  input handshake
- `in_idx_i`  in  IDX_W  slot number of the current input packet
- `in_packet_i`  in  W*PACKET_LENGTH  row r occupies bits `[r*PACKET_LENGTH +: PACKET_LENGTH]`
- `out_valid_o` / `out_ready_i`  out/in  1  output handshake
- `out_packet_o`  out  W*PACKET_LENGTH  reconstructed packet, same row packing
- `out_idx_o`  out  IDX_W  copy of the latched erased slot
- `busy_o`  out  1  high whenever the FSM is not in IDLE
- `err_o`  out  1  sticky protocol-error flag

## Operation
- FSM states are IDLE, COLLECT and OUTPUT.
- IDLE → COLLECT on `start_i=1` with `erased_idx_i ≤ K_MAX`. This latches the erased slot, clears the accumulator, the `seen` mask (K_MAX+1 bits) and `cnt`, and clears `err_o`.
- In IDLE, `start_i=1` with `erased_idx_i > K_MAX`: set `err_o`, stay in IDLE.
- COLLECT: `in_ready_o=1`. A beat is accepted when `in_valid_i & in_ready_o`. Each accepted beat is handled as follows:
  - If `in_idx_i` equals the erased slot, exceeds K_MAX, or is already in `seen`: the beat is consumed and discarded, and `err_o` is set.
  - Otherwise: `acc ^= in_packet_i` (all W rows in parallel), `seen[in_idx_i]=1`, `cnt++`.
- COLLECT → OUTPUT on the edge where `cnt` reaches K_MAX.
- OUTPUT: `out_valid_o=1` and `in_ready_o=0`. `out_packet_o=acc` and `out_idx_o` are held stable until `out_ready_i=1`, then the FSM returns to IDLE.
- `start_i` outside IDLE is ignored and does not set `err_o`.
- Reset values: `in_ready_o=0`, `out_valid_o=0`, `out_packet_o=0`, `out_idx_o=0`, `busy_o=0`, `err_o=0`, FSM=IDLE, accumulator, `seen` and `cnt` cleared.
- Reset asserted mid-operation aborts the operation at the next edge; no partial output is ever emitted.

## Timing
- Start accepted at edge T: `in_ready_o=1` and `busy_o=1` from T+1.
- Last valid beat accepted at edge N: `out_valid_o=1` from N+1. No combinational path exists from input to output.
- Output handshake at edge M: the FSM is in IDLE from M+1, and the next start is accepted no earlier than M+1.
- Minimum operation length is K_MAX+2 cycles from start to output handshake, with one input beat per cycle and no input bubbles required.
- `err_o` rises the cycle after the offending beat or start. It clears only on the next accepted start or on reset.

## Structure
- `IDX_W` and the state encodings are localparams. Shared sizes (W, K_MAX, PACKET_LENGTH) come only from `global_parameters.v`.
- Sub-module `packet_xor_accum`: a W×PACKET_LENGTH register with `clr` and `xor_en` inputs. It takes the `in_packet_i` data input and exposes the accumulator value as its output. The FSM, `seen`/`cnt` tracking and handshake logic stay in the top module.

## Test plan
(Parameters: W=8, K_MAX=4, PACKET_LENGTH=32. Dn means every row equals 0x0n0n0n0n. P = D0^D1^D2^D3.)
- Erase slot 2; feed slots 0,1,3,4 (P) back-to-back → `out_packet_o` = D2 in all rows, `out_idx_o`=2, `out_valid_o` rises 1 cycle after the 4th beat, `err_o`=0.
- Erase slot 4 (parity); feed 0,1,2,3 → output equals P in all rows.
- Erase slot 1; feed 3,0,3,4,2 → `err_o`=1 after the 3rd beat; the duplicate is not accumulated; output = D1 after the 5th beat.
- Erase slot 0; hold `out_ready_i=0` for 5 cycles after `out_valid_o` rises → output data and index stay stable, `in_ready_o`=0; handshake then returns the FSM to IDLE with `busy_o`=0.
- Pull `rst_n` low for 1 cycle after 2 accepted beats → all outputs are at reset values. A following full recovery (erase 2) yields D2.
- `start_i` with `erased_idx_i`=5 → `err_o`=1, `busy_o` stays 0, `in_ready_o` stays 0.

Source files
------------

// File: rtl/packet_xor_recover_pkg.sv
// Shared sizes, derived widths and FSM state type for the XOR erasure-recovery
// engine and its accumulator.
//   W             rows (words) per packet
//   K_MAX         data packets per stripe; slot K_MAX is the parity packet
//   PACKET_LENGTH bits per row
//   IDX_W         width of a slot index (0..K_MAX)
//   PKT_BITS      total packet width, row r at [r*PACKET_LENGTH +: PACKET_LENGTH]
package packet_xor_recover_pkg;

  localparam int unsigned W             = 8;
  localparam int unsigned K_MAX         = 4;
  localparam int unsigned PACKET_LENGTH = 32;

  localparam int unsigned IDX_W    = $clog2(K_MAX + 1);
  localparam int unsigned PKT_BITS = W * PACKET_LENGTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_OUTPUT
  } state_t;

  // A slot index names a real packet only if it is 0..K_MAX.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) <= K_MAX;
  endfunction

endpackage

// File: rtl/packet_xor_accum.sv
// W x PACKET_LENGTH XOR accumulator. All rows are XORed in parallel.
//   clk          rising-edge clock
//   clr          synchronous clear (wins over xor_en)
//   xor_en       fold in_packet_i into the accumulator this edge
//   in_packet_i  packet to accumulate
//   acc          current accumulator value
module packet_xor_accum
  import packet_xor_recover_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic                xor_en,
  input  logic [PKT_BITS-1:0] in_packet_i,
  output logic [PKT_BITS-1:0] acc
);

  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
    end else if (xor_en) begin
      acc <= acc ^ in_packet_i;
    end
  end

endmodule

// File: rtl/packet_xor_recover.sv
// Sequential erasure-recovery engine: the host names one erased slot, streams
// the K_MAX survivors in any order, and the XOR of the survivors is presented
// as the reconstructed packet.
//   clk, rst_n                  clock, synchronous active-low reset
//   start_i, erased_idx_i       begin a recovery of slot erased_idx_i (IDLE only)
//   in_valid_i/in_ready_o       input handshake, in_idx_i names the slot of in_packet_i
//   out_valid_o/out_ready_i     output handshake for out_packet_o / out_idx_o
//   busy_o                      FSM not in IDLE
//   err_o                       sticky protocol error, cleared by next accepted start
module packet_xor_recover
  import packet_xor_recover_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [IDX_W-1:0]    erased_idx_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IDX_W-1:0]    in_idx_i,
  input  logic [PKT_BITS-1:0] in_packet_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [PKT_BITS-1:0] out_packet_o,
  output logic [IDX_W-1:0]    out_idx_o,
  output logic                busy_o,
  output logic                err_o
);

  state_t           state;
  logic [K_MAX:0]   seen;
  logic [IDX_W-1:0] cnt;

  logic [K_MAX:0]   idx_onehot;
  logic             seen_hit;
  logic             accept;
  logic             beat_bad;
  logic             start_ok;
  logic             acc_clr;
  logic             acc_xor_en;

  // Decode in_idx_i against the seen mask without indexing past K_MAX.
  always_comb begin
    idx_onehot = '0;
    seen_hit   = 1'b0;
    for (int unsigned i = 0; i <= K_MAX; i++) begin
      if (in_idx_i == IDX_W'(i)) begin
        idx_onehot[i] = 1'b1;
        seen_hit      = seen[i];
      end
    end
  end

  // out_idx_o doubles as the latched erased slot.
  assign beat_bad   = (in_idx_i == out_idx_o) || !idx_in_range(in_idx_i) || seen_hit;
  assign accept     = in_valid_i && in_ready_o;
  assign start_ok   = (state == ST_IDLE) && start_i && idx_in_range(erased_idx_i);
  assign acc_clr    = !rst_n || start_ok;
  assign acc_xor_en = accept && !beat_bad;

  packet_xor_accum u_accum (
    .clk         (clk),
    .clr         (acc_clr),
    .xor_en      (acc_xor_en),
    .in_packet_i (in_packet_i),
    .acc         (out_packet_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      seen        <= '0;
      cnt         <= '0;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      out_idx_o   <= '0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (idx_in_range(erased_idx_i)) begin
              state      <= ST_COLLECT;
              out_idx_o  <= erased_idx_i;
              seen       <= '0;
              cnt        <= '0;
              err_o      <= 1'b0;
              in_ready_o <= 1'b1;
              busy_o     <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            if (beat_bad) begin
              err_o <= 1'b1;
            end else begin
              seen <= seen | idx_onehot;
              cnt  <= cnt + 1'b1;
              if (cnt == IDX_W'(K_MAX - 1)) begin
                state       <= ST_OUTPUT;
                in_ready_o  <= 1'b0;
                out_valid_o <= 1'b1;
              end
            end
          end
        end
        ST_OUTPUT: begin
          if (out_ready_i) begin
            state       <= ST_IDLE;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_o  <= 1'b0;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_xor_recover.sv
module tb_packet_xor_recover;
  import packet_xor_recover_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start_i;
  logic [IDX_W-1:0]    erased_idx_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [IDX_W-1:0]    in_idx_i;
  logic [PKT_BITS-1:0] in_packet_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [PKT_BITS-1:0] out_packet_o;
  logic [IDX_W-1:0]    out_idx_o;
  logic                busy_o;
  logic                err_o;

  typedef struct {
    logic [IDX_W-1:0]    idx;
    logic [PKT_BITS-1:0] pkt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  packet_xor_recover dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .erased_idx_i (erased_idx_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_idx_i     (in_idx_i),
    .in_packet_i  (in_packet_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_packet_o (out_packet_o),
    .out_idx_o    (out_idx_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [PKT_BITS-1:0] obs,
                       input logic [PKT_BITS-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [PKT_BITS-1:0] dpat(input int unsigned n);
    logic [PKT_BITS-1:0] p;
    logic [7:0]          b;
    b = 8'(n);
    for (int unsigned r = 0; r < W; r++) p[r*PACKET_LENGTH +: PACKET_LENGTH] = {4{b}};
    return p;
  endfunction

  function automatic logic [PKT_BITS-1:0] rand_pkt();
    logic [PKT_BITS-1:0] p;
    for (int unsigned r = 0; r < W; r++) p[r*PACKET_LENGTH +: PACKET_LENGTH] = $urandom;
    return p;
  endfunction

  // Start a recovery and record the packet the bench expects back.
  task automatic start_rec(input int unsigned idx, input logic [PKT_BITS-1:0] exp_pkt);
    exp_t e;
    e.idx = IDX_W'(idx);
    e.pkt = exp_pkt;
    exp_q.push_back(e);
    start_i      = 1'b1;
    erased_idx_i = IDX_W'(idx);
    tick();
    start_i = 1'b0;
    check("start_in_ready", PKT_BITS'(in_ready_o), PKT_BITS'(1));
    check("start_busy", PKT_BITS'(busy_o), PKT_BITS'(1));
  endtask

  // One input beat; waits (bounded) for in_ready_o before the accepting edge.
  task automatic send(input int unsigned idx, input logic [PKT_BITS-1:0] pkt);
    int n;
    in_valid_i  = 1'b1;
    in_idx_i    = IDX_W'(idx);
    in_packet_i = pkt;
    n = 0;
    while (!in_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("in_ready_timeout", PKT_BITS'(in_ready_o), PKT_BITS'(1));
    tick();
    in_valid_i = 1'b0;
  endtask

  // Output must already be valid; compare against the scoreboard, optionally
  // hold off the handshake, then complete it.
  task automatic take_output(input int unsigned hold);
    exp_t e;
    check("out_valid", PKT_BITS'(out_valid_o), PKT_BITS'(1));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", PKT_BITS'(exp_q.size()), PKT_BITS'(1));
    end else begin
      e = exp_q.pop_front();
      check("out_packet", out_packet_o, e.pkt);
      check("out_idx", PKT_BITS'(out_idx_o), PKT_BITS'(e.idx));
      for (int unsigned c = 0; c < hold; c++) begin
        tick();
        check("hold_valid", PKT_BITS'(out_valid_o), PKT_BITS'(1));
        check("hold_packet", out_packet_o, e.pkt);
        check("hold_idx", PKT_BITS'(out_idx_o), PKT_BITS'(e.idx));
        check("hold_in_ready", PKT_BITS'(in_ready_o), PKT_BITS'(0));
      end
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("post_hs_valid", PKT_BITS'(out_valid_o), PKT_BITS'(0));
    check("post_hs_busy", PKT_BITS'(busy_o), PKT_BITS'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, PKT_BITS'(in_ready_o), '0);
    check({tag, "_out_valid"}, PKT_BITS'(out_valid_o), '0);
    check({tag, "_out_packet"}, out_packet_o, '0);
    check({tag, "_out_idx"}, PKT_BITS'(out_idx_o), '0);
    check({tag, "_busy"}, PKT_BITS'(busy_o), '0);
    check({tag, "_err"}, PKT_BITS'(err_o), '0);
  endtask

  logic [PKT_BITS-1:0] p_par;
  logic [PKT_BITS-1:0] r0, r1, r2, r4;

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    erased_idx_i = '0;
    in_valid_i   = 1'b0;
    in_idx_i     = '0;
    in_packet_i  = '0;
    out_ready_i  = 1'b0;
    p_par = dpat(0) ^ dpat(1) ^ dpat(2) ^ dpat(3);

    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Erase 2, survivors back-to-back; output valid right after 4th beat.
    start_rec(2, dpat(2));
    send(0, dpat(0));
    send(1, dpat(1));
    send(3, dpat(3));
    check("t1_valid_early", PKT_BITS'(out_valid_o), PKT_BITS'(0));
    send(4, p_par);
    check("t1_err", PKT_BITS'(err_o), PKT_BITS'(0));
    take_output(0);

    // Erase parity.
    start_rec(4, p_par);
    send(0, dpat(0));
    send(1, dpat(1));
    send(2, dpat(2));
    send(3, dpat(3));
    take_output(0);

    // Erase 1 with a duplicate beat that must be discarded.
    start_rec(1, dpat(1));
    send(3, dpat(3));
    send(0, dpat(0));
    check("t3_err_before_dup", PKT_BITS'(err_o), PKT_BITS'(0));
    send(3, dpat(3));
    check("t3_err_after_dup", PKT_BITS'(err_o), PKT_BITS'(1));
    send(4, p_par);
    check("t3_valid_early", PKT_BITS'(out_valid_o), PKT_BITS'(0));
    send(2, dpat(2));
    take_output(0);

    // Erase 0, back-pressure for 5 cycles; err from previous run cleared.
    start_rec(0, dpat(0));
    check("t4_err_cleared", PKT_BITS'(err_o), PKT_BITS'(0));
    send(1, dpat(1));
    send(2, dpat(2));
    send(3, dpat(3));
    send(4, p_par);
    take_output(5);

    // Reset after two beats aborts; then a full recovery.
    start_rec(2, dpat(2));
    send(0, dpat(0));
    send(1, dpat(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check_reset_outputs("midreset");
    start_rec(2, dpat(2));
    send(0, dpat(0));
    send(1, dpat(1));
    send(3, dpat(3));
    send(4, p_par);
    take_output(0);

    // Out-of-range erased slot.
    start_i      = 1'b1;
    erased_idx_i = IDX_W'(5);
    tick();
    start_i = 1'b0;
    check("badstart_err", PKT_BITS'(err_o), PKT_BITS'(1));
    check("badstart_busy", PKT_BITS'(busy_o), PKT_BITS'(0));
    check("badstart_in_ready", PKT_BITS'(in_ready_o), PKT_BITS'(0));
    tick();
    check("badstart_busy2", PKT_BITS'(busy_o), PKT_BITS'(0));

    // Random survivors with bubbles and a stray start during COLLECT.
    r0 = rand_pkt();
    r1 = rand_pkt();
    r2 = rand_pkt();
    r4 = rand_pkt();
    start_rec(3, r0 ^ r1 ^ r2 ^ r4);
    check("t7_err_cleared", PKT_BITS'(err_o), PKT_BITS'(0));
    send(4, r4);
    tick();
    start_i      = 1'b1;
    erased_idx_i = IDX_W'(6);
    send(1, r1);
    start_i = 1'b0;
    send(7, rand_pkt());
    check("t7_err_badidx", PKT_BITS'(err_o), PKT_BITS'(1));
    tick();
    send(2, r2);
    send(0, r0);
    take_output(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
